// File: rtl/drv_switch_bank.sv
// drv_switch_bank: multi-channel debounced button/switch driver.
// Each channel: 2-flop synchroniser, polarity normalisation, stability-counter
// debounce, and an IDLE/HELD/LONG event FSM producing press/click/release,
// toggle, long-press and (optionally) auto-repeat outputs.
// Optional feature: define DRV_SWITCH_BANK_REPEAT_EN to build the auto-repeat
// logic; without it o_repeat is constant 0 and p_repeat_cycles is ignored.
module drv_switch_bank #(
  parameter int unsigned           p_channels      = 4,
  parameter int unsigned           p_scale         = 5,
  parameter logic [p_channels-1:0] p_pullup_mask   = {p_channels{1'b1}},
  parameter int unsigned           p_long_cycles   = 1000,
  parameter int unsigned           p_repeat_cycles = 250
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_channels-1:0] i_drv_sw,
  output logic [p_channels-1:0] o_press,
  output logic [p_channels-1:0] o_click,
  output logic [p_channels-1:0] o_release,
  output logic [p_channels-1:0] o_toggle,
  output logic [p_channels-1:0] o_long,
  output logic [p_channels-1:0] o_repeat
);

  localparam int unsigned CNT_W    = p_scale;
  localparam int unsigned HOLD_MAX = (p_long_cycles > p_repeat_cycles) ? p_long_cycles
                                                                       : p_repeat_cycles;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } fsm_t;

  logic [p_channels-1:0] sync_a;
  logic [p_channels-1:0] sync_b;
  logic [p_channels-1:0] s;

  // Two-flop synchroniser; reset loads the inactive pad level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_a <= p_pullup_mask;
      sync_b <= p_pullup_mask;
    end else begin
      sync_a <= i_drv_sw;
      sync_b <= sync_a;
    end
  end

  // Polarity normalisation: 1 means active on every channel
  assign s = sync_b ^ p_pullup_mask;

  for (genvar g = 0; g < p_channels; g++) begin : g_ch
    logic [CNT_W-1:0]  cnt;
    logic              deb;
    fsm_t              fsm;
    fsm_t              fsm_nx;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nx;
    logic              click_nx;
    logic              release_nx;
    logic              long_nx;
    logic              repeat_nx;
    logic              press_q;
    logic              click_q;
    logic              release_q;
    logic              toggle_q;
    logic              long_q;
    logic              repeat_q;

    // Debounce: flip only after 2**p_scale consecutive differing samples
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        deb <= 1'b0;
        cnt <= '0;
      end else if (s[g] == deb) begin
        cnt <= '0;
      end else if (cnt == {CNT_W{1'b1}}) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    // FSM state, hold counter and registered outputs
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        fsm       <= IDLE;
        hold      <= '0;
        press_q   <= 1'b0;
        click_q   <= 1'b0;
        release_q <= 1'b0;
        toggle_q  <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        fsm       <= fsm_nx;
        hold      <= hold_nx;
        press_q   <= deb;
        click_q   <= click_nx;
        release_q <= release_nx;
        toggle_q  <= toggle_q ^ click_q;
        long_q    <= long_nx;
        repeat_q  <= repeat_nx;
      end
    end

    // Next-state and event decode; a release always beats the long threshold
    always_comb begin
      fsm_nx     = fsm;
      hold_nx    = hold;
      click_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
      case (fsm)
        IDLE: begin
          if (deb) begin
            fsm_nx   = HELD;
            hold_nx  = '0;
            click_nx = 1'b1;
          end
        end
        HELD: begin
          if (!deb) begin
            fsm_nx     = IDLE;
            release_nx = 1'b1;
          end else if (hold == HOLD_W'(p_long_cycles - 1)) begin
            fsm_nx  = LONG;
            hold_nx = '0;
            long_nx = 1'b1;
          end else begin
            hold_nx = hold + HOLD_W'(1);
          end
        end
        LONG: begin
          if (!deb) begin
            fsm_nx     = IDLE;
            release_nx = 1'b1;
          end else begin
`ifdef DRV_SWITCH_BANK_REPEAT_EN
            if (hold == HOLD_W'(p_repeat_cycles - 1)) begin
              hold_nx   = '0;
              repeat_nx = 1'b1;
            end else begin
              hold_nx = hold + HOLD_W'(1);
            end
`else
            if (hold != {HOLD_W{1'b1}}) begin
              hold_nx = hold + HOLD_W'(1);
            end
`endif
          end
        end
        default: begin
          fsm_nx = IDLE;
        end
      endcase
    end

    assign o_press[g]   = press_q;
    assign o_click[g]   = click_q;
    assign o_release[g] = release_q;
    assign o_toggle[g]  = toggle_q;
    assign o_long[g]    = long_q;
    assign o_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_drv_switch_bank.sv
// tb_drv_switch_bank: directed self-checking bench for drv_switch_bank
// (4 channels, p_scale=2, ch0/ch2 pull-up, ch1/ch3 pull-down, long=20, repeat=5).
module tb_drv_switch_bank;

  localparam int unsigned N    = 4;
  localparam logic [3:0]  MASK = 4'b0101;

  logic         clk;
  logic         rst;
  logic [N-1:0] sw;
  logic [N-1:0] o_press;
  logic [N-1:0] o_click;
  logic [N-1:0] o_release;
  logic [N-1:0] o_toggle;
  logic [N-1:0] o_long;
  logic [N-1:0] o_repeat;
  logic [23:0]  outs;

  int n_checks;
  int n_fail;
  int viol;
  logic seen_rep;

  drv_switch_bank #(
    .p_channels      (N),
    .p_scale         (2),
    .p_pullup_mask   (MASK),
    .p_long_cycles   (20),
    .p_repeat_cycles (5)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_drv_sw  (sw),
    .o_press   (o_press),
    .o_click   (o_click),
    .o_release (o_release),
    .o_toggle  (o_toggle),
    .o_long    (o_long),
    .o_repeat  (o_repeat)
  );

  assign outs = {o_press, o_click, o_release, o_toggle, o_long, o_repeat};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exclusivity monitor across the whole run
  always @(negedge clk) begin
    if (!rst) begin
      if (|(o_long & o_repeat)) viol++;
      if (|(o_click & o_release)) viol++;
      if (|o_repeat) seen_rep = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    viol     = 0;
    seen_rep = 1'b0;
    rst      = 1'b1;
    sw       = MASK;

    // Reset state
    step(3);
    check("reset_outs", 32'(outs), 32'h0);
    rst = 1'b0;
    step(2);
    check("idle_outs", 32'(outs), 32'h0);

    // Glitch rejection: ch0 active for 3 samples only
    sw[0] = 1'b0;
    step(3);
    sw[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step(1);
      check("glitch_quiet", 32'(outs), 32'h0);
    end

    // Clean press on ch1 (pull-down)
    sw[1] = 1'b1;
    step(6);
    check("p1_early", 32'(o_press), 32'h0);
    step(1);
    check("p1_press", 32'(o_press), 32'h2);
    check("p1_click", 32'(o_click), 32'h2);
    check("p1_tog_T", 32'(o_toggle), 32'h0);
    step(1);
    check("p1_click_end", 32'(o_click), 32'h0);
    check("p1_tog", 32'(o_toggle), 32'h2);
    sw[1] = 1'b0;
    step(6);
    check("p1_still", 32'(o_press), 32'h2);
    step(1);
    check("p1_rel_press", 32'(o_press), 32'h0);
    check("p1_release", 32'(o_release), 32'h2);
    step(1);
    check("p1_release_end", 32'(o_release), 32'h0);
    // Second press returns toggle to 0
    sw[1] = 1'b1;
    step(7);
    check("p1b_click", 32'(o_click), 32'h2);
    step(1);
    check("p1b_tog", 32'(o_toggle), 32'h0);
    sw[1] = 1'b0;
    step(7);
    check("p1b_release", 32'(o_release), 32'h2);
    step(2);

    // Long press with repeat on ch0 (pull-up)
    sw[0] = 1'b0;
    step(6);
    check("lp_early", 32'(o_press), 32'h0);
    step(1);
    check("lp_click", 32'(o_click), 32'h1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check("lp_long", 32'(o_long), (k == 20) ? 32'h1 : 32'h0);
`ifdef DRV_SWITCH_BANK_REPEAT_EN
      check("lp_repeat", 32'(o_repeat), (k > 20 && (k - 20) % 5 == 0) ? 32'h1 : 32'h0);
`else
      check("lp_repeat", 32'(o_repeat), 32'h0);
`endif
    end
    sw[0] = 1'b1;
    step(7);
    check("lp_release", 32'(o_release), 32'h1);
    check("lp_rel_press", 32'(o_press), 32'h0);
    step(2);

    // Release coinciding with the long threshold
    sw[0] = 1'b0;
    step(7);
    check("th_click", 32'(o_click), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 14) sw[0] = 1'b1;
      step(1);
      check("th_no_long", 32'(o_long), 32'h0);
      if (k == 19) check("th_press_19", 32'(o_press), 32'h1);
      if (k == 20) begin
        check("th_press_20", 32'(o_press), 32'h0);
        check("th_release", 32'(o_release), 32'h1);
      end
    end
    step(1);
    check("th_no_long_after", 32'(o_long), 32'h0);
    check("th_tog", 32'(o_toggle), 32'h0);
    step(2);

    // All channels pressed together, released 3 cycles apart
    sw = ~MASK;
    step(7);
    check("all_click", 32'(o_click), 32'hF);
    check("all_press", 32'(o_press), 32'hF);
    for (int k = 1; k <= 19; k++) begin
      if (k == 2)  sw[0] = 1'b1;
      if (k == 5)  sw[1] = 1'b0;
      if (k == 8)  sw[2] = 1'b1;
      if (k == 11) sw[3] = 1'b0;
      step(1);
      check("stag_release", 32'(o_release),
            {28'h0, (k == 17), (k == 14), (k == 11), (k == 8)});
      check("stag_no_long", 32'(o_long), 32'h0);
    end
    check("all_tog", 32'(o_toggle), 32'hF);
    check("all_idle", 32'(o_press), 32'h0);
    step(2);

    // Reset in the middle of a held press on ch0
    sw[0] = 1'b0;
    step(7);
    check("rs_click", 32'(o_click), 32'h1);
    step(10);
    rst = 1'b1;
    step(1);
    check("rs_outs", 32'(outs), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      check("rs_click_again", 32'(o_click), (k == 7) ? 32'h1 : 32'h0);
      check("rs_no_release", 32'(o_release), 32'h0);
    end
    step(1);
    check("rs_tog", 32'(o_toggle), 32'h1);
    sw[0] = 1'b1;
    step(10);

    check("exclusivity", 32'(viol), 32'h0);
`ifdef DRV_SWITCH_BANK_REPEAT_EN
    check("repeat_seen", 32'(seen_rep), 32'h1);
`else
    check("repeat_never", 32'(seen_rep), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
